// File: rtl/keypad_debouncer.sv
// rtl/keypad_debouncer.sv - synchronise, debounce and encode an active-low keypad
module keypad_debouncer #(
   parameter int N_KEYS          = 12,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] keypad_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic              key_valid,
   output logic [3:0]        key_code,
   output logic              key_any
);

   typedef enum logic [1:0] {
      ST_UP     = 2'd0,
      ST_DEB_DN = 2'd1,
      ST_DOWN   = 2'd2,
      ST_DEB_UP = 2'd3
   } key_state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_KEYS-1:0] sync_meta;
   logic [N_KEYS-1:0] sync_out;
   logic [N_KEYS-1:0] pressed;

   key_state_t        state_q [N_KEYS];
   key_state_t        state_d [N_KEYS];
   logic [CNT_W-1:0]  cnt_q   [N_KEYS];
   logic [CNT_W-1:0]  cnt_d   [N_KEYS];

   logic [N_KEYS-1:0] level_d;
   logic [N_KEYS-1:0] press_d;
   logic [N_KEYS-1:0] release_d;
   logic [3:0]        code_d;

   // Two-flop synchroniser; resets to the released (raw high) level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_meta <= '1;
         sync_out  <= '1;
      end else begin
         sync_meta <= keypad_in;
         sync_out  <= sync_meta;
      end
   end

   assign pressed = ~sync_out;

   // Per-key debounce state and hold counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_KEYS; i++) begin
            state_q[i] <= ST_UP;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N_KEYS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // Next-state: a new level must hold for DEBOUNCE_CYCLES samples before it is accepted.
   always_comb begin
      level_d = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_UP: begin
               if (pressed[i]) begin
                  state_d[i] = ST_DEB_DN;
                  cnt_d[i]   = '0;
               end
            end
            ST_DEB_DN: begin
               if (!pressed[i]) begin
                  state_d[i] = ST_UP;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = ST_DOWN;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            ST_DOWN: begin
               if (!pressed[i]) begin
                  state_d[i] = ST_DEB_UP;
                  cnt_d[i]   = '0;
               end
            end
            ST_DEB_UP: begin
               if (pressed[i]) begin
                  state_d[i] = ST_DOWN;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = ST_UP;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = ST_UP;
               cnt_d[i]   = '0;
            end
         endcase
         level_d[i] = (state_d[i] == ST_DOWN) || (state_d[i] == ST_DEB_UP);
      end
   end

   // Edge detection and priority encode; the lowest pressed index wins.
   always_comb begin
      press_d   = level_d & ~key_level;
      release_d = ~level_d & key_level;
      code_d    = key_code;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (press_d[i]) begin
            code_d = 4'(i);
         end
      end
   end

   // Registered outputs; key_code holds between press events.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_level   <= '0;
         key_press   <= '0;
         key_release <= '0;
         key_valid   <= 1'b0;
         key_code    <= 4'd0;
         key_any     <= 1'b0;
      end else begin
         key_level   <= level_d;
         key_press   <= press_d;
         key_release <= release_d;
         key_valid   <= |press_d;
         key_code    <= code_d;
         key_any     <= |level_d;
      end
   end

endmodule
